pll_lock_supervisor: RTL



---
 rtl/pll_lock_supervisor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL reset, qualifies pll_lock and gates sys_rst_n on a stable lock.
// Build option: define PLL_SUP_GLITCH_FILTER_EN so that lock dropouts of 1-3 cycles in RUN are ignored.
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 100000,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned RST_W = $clog2(RST_PULSE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              lock_s;
  logic              lock_loss_s;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]  stb_cnt_q, stb_cnt_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [7:0]        relock_cnt_q, relock_cnt_d;
  logic              pll_rst_q, pll_rst_d;
  logic              sys_rst_n_q, sys_rst_n_d;
  logic              locked_q, locked_d;
  logic              fail_q, fail_d;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

`ifdef PLL_SUP_GLITCH_FILTER_EN
  logic [1:0] low_cnt_q, low_cnt_d;

  // Lock loss in RUN only after four consecutive low samples
  always_comb begin
    low_cnt_d   = 2'd0;
    lock_loss_s = 1'b0;
    if ((state_q == ST_RUN) && !lock_s) begin
      if (low_cnt_q == 2'd3) begin
        lock_loss_s = 1'b1;
        low_cnt_d   = low_cnt_q;
      end else begin
        low_cnt_d = low_cnt_q + 2'd1;
      end
    end else begin
      low_cnt_d = 2'd0;
    end
  end

  // Dropout length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q <= 2'd0;
    end else begin
      low_cnt_q <= low_cnt_d;
    end
  end
`else
  assign lock_loss_s = (state_q == ST_RUN) && !lock_s;
`endif

  // Next-state, counters and output decode
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    to_cnt_d     = to_cnt_q;
    stb_cnt_d    = stb_cnt_q;
    retry_d      = retry_q;
    relock_cnt_d = relock_cnt_q;

    if (restart) begin
      state_d = ST_PLL_RST;
      retry_d = {RTY_W{1'b0}};
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (to_cnt_q == TO_LAST) begin
            retry_d = retry_q + RTY_W'(1);
            if (retry_q == RTY_LAST) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_PLL_RST;
            end
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d = ST_RUN;
            retry_d = {RTY_W{1'b0}};
          end else begin
            stb_cnt_d = stb_cnt_q + STB_W'(1);
          end
        end
        ST_RUN: begin
          if (lock_loss_s) begin
            state_d = ST_PLL_RST;
            if (relock_cnt_q != 8'hFF) begin
              relock_cnt_d = relock_cnt_q + 8'd1;
            end else begin
              relock_cnt_d = relock_cnt_q;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_PLL_RST;
        end
      endcase
    end

    if (restart || (state_d != state_q)) begin
      rst_cnt_d = {RST_W{1'b0}};
      to_cnt_d  = {TO_W{1'b0}};
      stb_cnt_d = {STB_W{1'b0}};
    end else begin
      rst_cnt_d = rst_cnt_d;
    end

    // sys_rst_n drops on the same edge that leaves RUN, so lock loss is seen one cycle after detection
    pll_rst_d   = (state_q == ST_PLL_RST);
    fail_d      = (state_q == ST_FAIL);
    sys_rst_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    locked_d    = sys_rst_n_d;
  end

  // State, counter and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PLL_RST;
      rst_cnt_q    <= {RST_W{1'b0}};
      to_cnt_q     <= {TO_W{1'b0}};
      stb_cnt_q    <= {STB_W{1'b0}};
      retry_q      <= {RTY_W{1'b0}};
      relock_cnt_q <= 8'd0;
      pll_rst_q    <= 1'b1;
      sys_rst_n_q  <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      stb_cnt_q    <= stb_cnt_d;
      retry_q      <= retry_d;
      relock_cnt_q <= relock_cnt_d;
      pll_rst_q    <= pll_rst_d;
      sys_rst_n_q  <= sys_rst_n_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign relock_cnt = relock_cnt_q;

endmodule
